// File: rtl/hack_pkg.sv
// Shared Hack definitions: word width, PC reset vector and single-bit gate
// primitives used to build datapaths structurally.
package hack_pkg;

  localparam int HACK_WORD_W = 16;
  localparam logic [HACK_WORD_W-1:0] HACK_PC_RESET_VEC = 16'h0000;

  typedef logic [HACK_WORD_W-1:0] hack_word_t;

  function automatic logic gate_nand(input logic a, input logic b);
    return ~(a & b);
  endfunction

  function automatic logic gate_not(input logic a);
    return gate_nand(a, a);
  endfunction

  function automatic logic gate_and(input logic a, input logic b);
    return gate_not(gate_nand(a, b));
  endfunction

  function automatic logic gate_or(input logic a, input logic b);
    return gate_nand(gate_not(a), gate_not(b));
  endfunction

  function automatic logic gate_xor(input logic a, input logic b);
    return a ^ b;
  endfunction

  // sel=1 picks b; a is fully masked so an X on the unselected leg stays out.
  function automatic logic gate_mux(input logic a, input logic b, input logic sel);
    return sel ? b : a;
  endfunction

endpackage

// File: rtl/hack_pc_inc_n.sv
// WIDTH-bit +1 incrementer: ripple of half-adders with carry-in tied high.
// cout is set only when a is all-ones.
module inc_n
  import hack_pkg::*;
#(
  parameter int WIDTH = HACK_WORD_W
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] carry;

  assign carry[0] = 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ha
    assign sum[i]     = gate_xor(a[i], carry[i]);
    assign carry[i+1] = gate_and(a[i], carry[i]);
  end

  assign cout = carry[WIDTH];

endmodule

// File: rtl/hack_pc.sv
// Hack program counter: reset > load > inc > hold, one-cycle registered update.
// Optional registered wrap pulse when HACK_PC_WRAP_FLAG_EN is defined.
module hack_pc
  import hack_pkg::*;
#(
  parameter int              WIDTH       = HACK_WORD_W,
  parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(HACK_PC_RESET_VEC)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic             inc,
  output logic [WIDTH-1:0] out
`ifdef HACK_PC_WRAP_FLAG_EN
  ,
  output logic             wrap
`endif
);

  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] out_d;
  logic [WIDTH-1:0] inc_val;
  logic [WIDTH-1:0] inc_sel;
  logic             wrap_carry;

  inc_n #(
    .WIDTH(WIDTH)
  ) u_inc (
    .a   (out_q),
    .sum (inc_val),
    .cout(wrap_carry)
  );

  // Mux chain: inc stage, then load stage; the reset stage is the flop's sync clear.
  for (genvar i = 0; i < WIDTH; i++) begin : g_mux
    assign inc_sel[i] = gate_mux(out_q[i], inc_val[i], inc);
    assign out_d[i]   = gate_mux(inc_sel[i], in[i], load);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= RESET_VALUE;
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

`ifdef HACK_PC_WRAP_FLAG_EN
  logic wrap_q;
  logic wrap_d;

  // Only a genuine increment of all-ones wraps; a load of 0 or all-ones never does.
  assign wrap_d = gate_and(gate_and(gate_not(load), inc), wrap_carry);

  always_ff @(posedge clk) begin
    if (reset) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign wrap = wrap_q;
`else
  logic unused_wrap_carry;
  assign unused_wrap_carry = wrap_carry;
`endif

endmodule
